// File: rtl/alu_vector_checker.sv
// alu_vector_checker: replays stored ALU/Shifter vectors, samples results after SETTLE cycles and scores them.
module alu_vector_checker #(
    parameter int DEPTH = 16,
    parameter int AW = 4,
    parameter int SETTLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [67:0]   wr_alu_inp,
    input  logic [33:0]   wr_alu_ans,
    input  logic [37:0]   wr_sft_inp,
    input  logic [31:0]   wr_sft_ans,
    input  logic [AW:0]   num_tests,
    input  logic          start,
    output logic [31:0]   alu_src1,
    output logic [31:0]   alu_src2,
    output logic          invert_a,
    output logic          invert_b,
    output logic [1:0]    operation,
    output logic          left_right,
    output logic [4:0]    shamt,
    output logic [31:0]   sft_src,
    input  logic [31:0]   result_alu,
    input  logic          zero,
    input  logic          overflow,
    input  logic [31:0]   result_sft,
    output logic          busy,
    output logic          done,
    output logic [AW+1:0] score,
    output logic [AW:0]   alu_fail_cnt,
    output logic [AW:0]   sft_fail_cnt,
    output logic [AW-1:0] first_fail_idx,
    output logic          first_fail_valid
);
    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_CHECK, S_DONE} state_t;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [3:0] LAST = 4'(SETTLE - 1);
    state_t state, next;
    logic [67:0] mem_alu_inp [DEPTH];
    logic [33:0] mem_alu_ans [DEPTH];
    logic [37:0] mem_sft_inp [DEPTH];
    logic [31:0] mem_sft_ans [DEPTH];
    logic [67:0] alu_drv;
    logic [37:0] sft_drv;
    logic [AW-1:0] idx;
    logic [AW:0] eff;
    logic [3:0] cnt;
    logic launch, more, alu_ok, sft_ok;
    assign {invert_a, invert_b, operation, alu_src1, alu_src2} = alu_drv;
    assign {left_right, shamt, sft_src} = sft_drv;
    assign launch = start && (state == S_IDLE || state == S_DONE);
    assign more = (AW+1)'(idx) + (AW+1)'(1) < eff;
    assign alu_ok = {overflow, zero, result_alu} == mem_alu_ans[idx];
    assign sft_ok = result_sft == mem_sft_ans[idx];
    always_comb begin
        next = state;
        busy = state == S_APPLY || state == S_SETTLE || state == S_CHECK;
        done = state == S_DONE;
        case (state)
            S_IDLE, S_DONE: next = !launch ? state : num_tests == '0 ? S_DONE : S_APPLY;
            S_APPLY: next = S_SETTLE;
            S_SETTLE: next = cnt == LAST ? S_CHECK : S_SETTLE;
            S_CHECK: next = more ? S_APPLY : S_DONE;
            default: next = S_IDLE;
        endcase
    end
    // Memory has no reset; the run engine owns it while busy.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem_alu_inp[wr_addr] <= wr_alu_inp;
            mem_alu_ans[wr_addr] <= wr_alu_ans;
            mem_sft_inp[wr_addr] <= wr_sft_inp;
            mem_sft_ans[wr_addr] <= wr_sft_ans;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx <= '0;
            eff <= '0;
            cnt <= '0;
            alu_drv <= '0;
            sft_drv <= '0;
            score <= '0;
            alu_fail_cnt <= '0;
            sft_fail_cnt <= '0;
            first_fail_idx <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            state <= next;
            if (launch) begin
                idx <= '0;
                eff <= num_tests > FULL ? FULL : num_tests;
                score <= '0;
                alu_fail_cnt <= '0;
                sft_fail_cnt <= '0;
                first_fail_idx <= '0;
                first_fail_valid <= 1'b0;
            end
            if (state == S_APPLY) begin
                alu_drv <= mem_alu_inp[idx];
                sft_drv <= mem_sft_inp[idx];
                cnt <= '0;
            end
            if (state == S_SETTLE)
                cnt <= cnt + 4'd1;
            if (state == S_CHECK) begin
                score <= score + (AW+2)'(alu_ok) + (AW+2)'(sft_ok);
                alu_fail_cnt <= alu_fail_cnt + (AW+1)'(!alu_ok);
                sft_fail_cnt <= sft_fail_cnt + (AW+1)'(!sft_ok);
                if (!(alu_ok && sft_ok) && !first_fail_valid) begin
                    first_fail_idx <= idx;
                    first_fail_valid <= 1'b1;
                end
                if (more)
                    idx <= idx + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_alu_vector_checker.sv
// tb_alu_vector_checker: behavioural ALU/Shifter beside the checker; expected run outcomes
// are queued at start and compared by a monitor when done appears.
module tb_alu_vector_checker;
    localparam int SET = 1;
    logic clk = 0, rst = 1, wr_en = 0, start = 0;
    logic [3:0] wr_addr = 0;
    logic [67:0] wr_alu_inp = 0;
    logic [33:0] wr_alu_ans = 0;
    logic [37:0] wr_sft_inp = 0;
    logic [31:0] wr_sft_ans = 0;
    logic [4:0] num_tests = 0;
    logic [31:0] alu_src1, alu_src2, sft_src, result_alu, result_sft;
    logic invert_a, invert_b, left_right, zero, overflow, busy, done, first_fail_valid;
    logic [1:0] operation;
    logic [4:0] shamt, alu_fail_cnt, sft_fail_cnt;
    logic [5:0] score;
    logic [3:0] first_fail_idx;
    logic [105:0] drv_now;
    int checks = 0, passes = 0;
    longint cyc = 0;
    logic armed = 0;
    logic [67:0] m_ai [16];
    logic [33:0] m_aa [16];
    logic [37:0] m_si [16];
    logic [31:0] m_sa [16];
    typedef struct {int score; int af; int sf; int fi; int fv; longint t;} exp_t;
    exp_t exp_q [$];
    exp_t got_e;

    // op 00 AND, 01 OR, 10 ADD (invert_b also adds the carry-in), 11 signed SLT
    function automatic logic [33:0] alu_f(input logic [67:0] v);
        logic [31:0] a, b, r;
        logic ov;
        a = v[67] ? ~v[63:32] : v[63:32];
        b = v[66] ? ~v[31:0] : v[31:0];
        ov = 1'b0;
        case (v[65:64])
            2'd0: r = a & b;
            2'd1: r = a | b;
            2'd2: begin
                r = a + b + {31'b0, v[66]};
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            default: r = {31'b0, $signed(a) < $signed(b)};
        endcase
        return {ov, r == 32'h0, r};
    endfunction

    function automatic logic [31:0] sft_f(input logic [37:0] v);
        return v[37] ? v[31:0] << v[36:32] : v[31:0] >> v[36:32];
    endfunction

    assign {overflow, zero, result_alu} = alu_f({invert_a, invert_b, operation, alu_src1, alu_src2});
    assign result_sft = sft_f({left_right, shamt, sft_src});
    assign drv_now = {invert_a, invert_b, operation, alu_src1, alu_src2, left_right, shamt, sft_src};

    alu_vector_checker #(.DEPTH(16), .AW(4), .SETTLE(SET)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_alu_inp(wr_alu_inp), .wr_alu_ans(wr_alu_ans),
        .wr_sft_inp(wr_sft_inp), .wr_sft_ans(wr_sft_ans),
        .num_tests(num_tests), .start(start),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .invert_a(invert_a), .invert_b(invert_b),
        .operation(operation), .left_right(left_right), .shamt(shamt), .sft_src(sft_src),
        .result_alu(result_alu), .zero(zero), .overflow(overflow), .result_sft(result_sft),
        .busy(busy), .done(done), .score(score),
        .alu_fail_cnt(alu_fail_cnt), .sft_fail_cnt(sft_fail_cnt),
        .first_fail_idx(first_fail_idx), .first_fail_valid(first_fail_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A start seen while idle arms the monitor; the next done retires one queued expectation.
    always @(negedge clk) begin
        if (rst) armed <= 1'b0;
        else begin
            if (armed && done) begin
                armed <= 1'b0;
                chk("sb_pending", exp_q.size(), 1);
                if (exp_q.size() != 0) begin
                    got_e = exp_q.pop_front();
                    chk("score", score, got_e.score);
                    chk("alu_fail_cnt", alu_fail_cnt, got_e.af);
                    chk("sft_fail_cnt", sft_fail_cnt, got_e.sf);
                    chk("first_fail_valid", first_fail_valid, got_e.fv);
                    chk("first_fail_idx", first_fail_idx, got_e.fi);
                    chk("latency", cyc, got_e.t);
                end
            end
            if (start && !busy) armed <= 1'b1;
        end
    end

    task automatic wr(input int i, input logic [67:0] ai, input logic [33:0] aa,
                      input logic [37:0] si, input logic [31:0] sa);
        wr_en = 1; wr_addr = 4'(i);
        wr_alu_inp = ai; wr_alu_ans = aa; wr_sft_inp = si; wr_sft_ans = sa;
        tick();
        wr_en = 0;
        m_ai[i] = ai; m_aa[i] = aa; m_si[i] = si; m_sa[i] = sa;
    endtask

    task automatic good(input int i, input logic [67:0] ai, input logic [37:0] si);
        wr(i, ai, alu_f(ai), si, sft_f(si));
    endtask

    task automatic run(input int n, input bit push);
        exp_t e;
        int eff;
        logic ao, so;
        e = '{default: 0};
        eff = n > 16 ? 16 : n;
        for (int i = 0; i < eff; i++) begin
            ao = alu_f(m_ai[i]) == m_aa[i];
            so = sft_f(m_si[i]) == m_sa[i];
            e.score += int'(ao) + int'(so);
            e.af += int'(!ao);
            e.sf += int'(!so);
            if (!(ao && so) && e.fv == 0) begin
                e.fv = 1;
                e.fi = i;
            end
        end
        e.t = cyc + 1 + eff * (SET + 2);
        if (push) exp_q.push_back(e);
        num_tests = 5'(n);
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 200) begin
            tick();
            b++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d runs without done, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic refill();
        for (int i = 0; i < 16; i++)
            good(i, {4'($urandom), 32'($urandom), 32'($urandom)}, {6'($urandom), 32'($urandom)});
    endtask

    initial begin
        logic [105:0] drv;
        int k, s;
        rst = 1;
        tick();
        tick();
        rst = 0;
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_score", score, 0);
        chk("rst_fail_cnts", {alu_fail_cnt, sft_fail_cnt}, 0);
        chk("rst_first_fail", {first_fail_valid, first_fail_idx}, 0);
        chk("rst_drive", drv_now, 0);
        refill();
        wr(0, {2'b00, 2'b10, 32'h7FFFFFFF, 32'h1}, {1'b1, 1'b0, 32'h80000000}, {1'b1, 5'd4, 32'hF}, 32'hF0);
        good(1, {4'b0000, 32'($urandom), 32'h0}, {1'b0, 5'd31, 32'h1});
        run(4, 1);
        drain();
        repeat (3) tick();
        chk("done_held", {done, busy}, 2'b10);
        chk("score_held", score, 8);
        wr(2, m_ai[2], m_aa[2] ^ 34'h1_0000_0000, m_si[2], m_sa[2]);
        run(4, 1);
        drain();
        good(2, m_ai[2], m_si[2]);
        drv = drv_now;
        run(0, 1);
        drain();
        chk("n0_drive_hold", drv_now, drv);
        // start and a slot-0 overwrite while busy must both be ignored
        run(4, 1);
        tick();
        start = 1; num_tests = 5'd2;
        wr_en = 1; wr_addr = 0; wr_alu_inp = '1; wr_alu_ans = '0; wr_sft_inp = '1; wr_sft_ans = '0;
        tick();
        start = 0; wr_en = 0;
        drain();
        run(4, 1);
        drain();
        run(4, 0);
        repeat (3) tick();
        rst = 1;
        tick();
        rst = 0;
        chk("abort_busy_done", {busy, done}, 0);
        chk("abort_score", score, 0);
        chk("abort_drive", drv_now, 0);
        run(4, 1);
        drain();
        run(17, 1);
        drain();
        for (int r = 0; r < 8; r++) begin
            refill();
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) begin
                s = $urandom_range(0, 15);
                if ($urandom_range(0, 1) == 1)
                    wr(s, m_ai[s], m_aa[s] ^ (34'h1 << $urandom_range(0, 33)), m_si[s], m_sa[s]);
                else
                    wr(s, m_ai[s], m_aa[s], m_si[s], m_sa[s] ^ (32'h1 << $urandom_range(0, 31)));
            end
            run($urandom_range(0, 20), 1);
            drain();
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end
endmodule

// File: doc/alu_vector_checker.md
Name: alu_vector_checker

Overview:
- Synthesizable stimulus-and-check engine that drives the ALU and Shifter from stored test vectors.
- Samples their results after a settle delay, compares them against stored answers and keeps a score.
- Sits beside the ALU/Shifter pair on the lab board and makes the check self-contained in hardware.
- Vector and answer bit layouts match the team's test-vector files, so the same data loads into either flow.

Parameters:
- DEPTH, 16, number of vector slots.
- AW, 4, slot address width, log2(DEPTH).
- SETTLE, 1, cycles between applying a vector and sampling results; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- wr_en  in  1  write one vector slot.
- wr_addr  in  AW  slot index.
- wr_alu_inp  in  68  bit [67] invertA, [66] invertB, [65:64] operation, [63:32] src1, [31:0] src2.
- wr_alu_ans  in  34  bit [33] overflow, [32] zero, [31:0] result.
- wr_sft_inp  in  38  bit [37] leftRight, [36:32] shamt, [31:0] source.
- wr_sft_ans  in  32  expected shifter result.
- num_tests  in  AW+1  vectors to run; values above DEPTH clamp to DEPTH.
- start  in  1  run request, sampled in IDLE or DONE only.
- alu_src1, alu_src2  out  32  to ALU.
- invert_a, invert_b  out  1  to ALU.
- operation  out  2  to ALU.
- left_right  out  1  to Shifter.
- shamt  out  5  to Shifter.
- sft_src  out  32  to Shifter.
- result_alu  in  32  from ALU.
- zero, overflow  in  1  from ALU.
- result_sft  in  32  from Shifter.
- busy  out  1  run in progress.
- done  out  1  run complete; held high until next start or rst.
- score  out  AW+2  passes; each vector contributes up to 2.
- alu_fail_cnt, sft_fail_cnt  out  AW+1  failing vectors per unit.
- first_fail_idx  out  AW  index of first vector with any failure.
- first_fail_valid  out  1  first_fail_idx meaningful.

Behaviour:
- Reset: state IDLE; every output 0; index and settle counter 0. Vector memory is not cleared.
- rst mid-run aborts the run; the reset values apply on the next cycle.
- Writes are accepted only when busy=0; wr_en while busy is ignored and memory is unchanged.
- State IDLE:
  - start=1 with num_tests>0 goes to APPLY. Index=0; score, fail counts and first_fail_* clear; busy=1.
  - start=1 with num_tests=0 goes to DONE; done=1 the next cycle and score=0.
- State APPLY: the slot[index] input fields are registered onto the drive ports at the exiting edge; goes to SETTLE.
- State SETTLE: counts SETTLE cycles, then goes to CHECK.
- State CHECK: samples the DUT results at the exiting edge.
  - ALU pass requires {overflow, zero, result_alu} == wr_alu_ans exactly.
  - Shifter pass requires result_sft == wr_sft_ans.
  - score increments by 0, 1 or 2 in a single cycle.
  - alu_fail_cnt and sft_fail_cnt each increment on their own failure.
  - On the first failing vector, first_fail_idx=index and first_fail_valid=1; later failures do not overwrite it.
  - Goes to APPLY with index+1 if index+1 < effective count, otherwise to DONE.
- State DONE: busy=0, done=1, results stable. start goes to APPLY (or to DONE again if num_tests=0).
- start while busy is ignored.
- Per-vector latency is SETTLE+2 cycles. Start-to-done is 1+N*(SETTLE+2) cycles.
- The index reaches DEPTH-1 at most; the full-depth run terminates with no wrap.
- num_tests is sampled only at start.
- Drive ports hold the last applied vector after DONE.

Test Plan:
- Load 4 correct vectors, SETTLE=1, start=1 for 1 cycle -> done rises 13 cycles later; score=8; both fail counts 0; first_fail_valid=0.
  - vec0: op=10, src1=0x7FFFFFFF, src2=0x00000001 -> ovf=1, zero=0, result=0x80000000.
  - vec0 shifter: left, shamt=4, src=0x0000000F -> 0x000000F0.
- Corrupt the zero bit of vector 2's ALU answer -> score=7, alu_fail_cnt=1, sft_fail_cnt=0, first_fail_idx=2, first_fail_valid=1.
- num_tests=0 with start -> done=1 on the next cycle; score=0; drive ports unchanged.
- Pulse start and wr_en (overwriting slot 0 with bad data) during busy -> run unaffected; a re-run still gives score=8.
- Assert rst in the 5th cycle of the run -> next cycle busy=0, done=0, score=0, drive ports 0; a fresh start gives score=8.
- num_tests=17, all 16 slots correct -> clamps to 16; done after 49 cycles; score=32 with no overflow of the score register.
